regs_wb_unit: RTL and testbench

Writeback stage directly upstream of the register file in the RISC-V ISS RTL. It accepts writeback requests from the control unit, either a finished ALU result or a pending load. For loads it waits for the memory response, aligns and sign/zero-extends the returned word, and then drives the register file's `RegfileWriteType` write port with a one-cycle sync pulse. It owns the only write path into the register file, so writes to x0 are discarded here.

---
 rtl/regs_wb_unit_pkg.sv | 34 +++
 rtl/regs_wb_unit_if.sv | 39 +++
 rtl/regs_wb_unit_load_extend.sv | 42 ++++
 rtl/regs_wb_unit.sv | 102 ++++++++++
 tb/tb_regs_wb_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/regs_wb_unit_pkg.sv
// Shared types for the writeback stage and the register file write port.
//   WbRequestType    : writeback request from the control unit
//   RegfileWriteType : register file write port payload (dst, dstdata)
//   WbStateType      : writeback stage state (IDLE, WAIT_MEM)
//   LB/LH/LW/LBU/LHU : load funct3 encodings
package top_level_types;

  typedef logic [31:0] unsigned_32;

  typedef struct packed {
    logic [4:0]  dst;
    unsigned_32  dstdata;
  } RegfileWriteType;

  typedef struct packed {
    logic [4:0]  dst;
    unsigned_32  data;
    logic        is_load;
    logic [2:0]  load_type;
    logic [1:0]  addr_lsb;
  } WbRequestType;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } WbStateType;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

endpackage

// File: rtl/regs_wb_unit_if.sv
// Bus bundle between control unit, memory, writeback stage and register file.
//   slave  modport: writeback stage side
//   master modport: environment side (control unit / memory / register file)
// WbToCtl_err exists only when REGS_WB_TIMEOUT_EN is defined.
interface regs_wb_unit_if;
  import top_level_types::*;

  WbRequestType    CtlToWb_port;
  logic            CtlToWb_port_sync;
  logic            WbToCtl_port_notify;
  unsigned_32      MemToWb_port;
  logic            MemToWb_port_sync;
  RegfileWriteType WbToRegs_port;
  logic            WbToRegs_port_sync;
`ifdef REGS_WB_TIMEOUT_EN
  logic            WbToCtl_err;

  modport slave (
    input  CtlToWb_port, CtlToWb_port_sync, MemToWb_port, MemToWb_port_sync,
    output WbToCtl_port_notify, WbToRegs_port, WbToRegs_port_sync, WbToCtl_err
  );

  modport master (
    output CtlToWb_port, CtlToWb_port_sync, MemToWb_port, MemToWb_port_sync,
    input  WbToCtl_port_notify, WbToRegs_port, WbToRegs_port_sync, WbToCtl_err
  );
`else
  modport slave (
    input  CtlToWb_port, CtlToWb_port_sync, MemToWb_port, MemToWb_port_sync,
    output WbToCtl_port_notify, WbToRegs_port, WbToRegs_port_sync
  );

  modport master (
    output CtlToWb_port, CtlToWb_port_sync, MemToWb_port, MemToWb_port_sync,
    input  WbToCtl_port_notify, WbToRegs_port, WbToRegs_port_sync
  );
`endif

endinterface

// File: rtl/regs_wb_unit_load_extend.sv
// Load data alignment and extension (purely combinational).
//   word      : raw 32-bit memory word
//   load_type : funct3 of the load (undefined codes behave as LW)
//   addr_lsb  : low address bits selecting byte / halfword
//   extended  : aligned, sign- or zero-extended result
module load_extend
  import top_level_types::*;
(
  input  unsigned_32  word,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lsb,
  output unsigned_32  extended
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = '0;
    case (addr_lsb)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
  end

  // Halfword selection uses only addr_lsb[1]; a misaligned bit 0 is ignored.
  assign halfSel = addr_lsb[1] ? word[31:16] : word[15:0];

  always_comb begin
    extended = word;
    case (load_type)
      LB:      extended = {{24{byteSel[7]}}, byteSel};
      LBU:     extended = {24'd0, byteSel};
      LH:      extended = {{16{halfSel[15]}}, halfSel};
      LHU:     extended = {16'd0, halfSel};
      default: extended = word;
    endcase
  end

endmodule

// File: rtl/regs_wb_unit.sv
// Writeback stage in front of the register file.
// Accepts ALU results (written the next cycle) or loads (waits for the memory
// word, extends it, then writes). Writes to x0 never raise the write strobe.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   wb   : regs_wb_unit_if.slave bundle (request/notify, memory data,
//          register file write port, optional timeout error)
// Optional feature: REGS_WB_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter, a
// load wait counter and the WbToCtl_err pulse.
module regs_wb_unit
  import top_level_types::*;
`ifdef REGS_WB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input logic          clk,
  input logic          rst,
  regs_wb_unit_if.slave wb
);

  WbStateType  state;
  logic [4:0]  ldDst;
  logic [2:0]  ldType;
  logic [1:0]  ldLsb;
  unsigned_32  ldExtended;

`ifdef REGS_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] waitCnt;
`endif

  load_extend uLoadExtend (
    .word      (wb.MemToWb_port),
    .load_type (ldType),
    .addr_lsb  (ldLsb),
    .extended  (ldExtended)
  );

  assign wb.WbToCtl_port_notify = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      ldDst                 <= '0;
      ldType                <= '0;
      ldLsb                 <= '0;
      wb.WbToRegs_port      <= '0;
      wb.WbToRegs_port_sync <= 1'b0;
`ifdef REGS_WB_TIMEOUT_EN
      waitCnt               <= '0;
      wb.WbToCtl_err        <= 1'b0;
`endif
    end else begin
      wb.WbToRegs_port_sync <= 1'b0;
`ifdef REGS_WB_TIMEOUT_EN
      wb.WbToCtl_err        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wb.CtlToWb_port_sync) begin
            if (wb.CtlToWb_port.is_load) begin
              ldDst  <= wb.CtlToWb_port.dst;
              ldType <= wb.CtlToWb_port.load_type;
              ldLsb  <= wb.CtlToWb_port.addr_lsb;
              state  <= WAIT_MEM;
`ifdef REGS_WB_TIMEOUT_EN
              waitCnt <= '0;
`endif
            end else begin
              wb.WbToRegs_port.dst     <= wb.CtlToWb_port.dst;
              wb.WbToRegs_port.dstdata <= wb.CtlToWb_port.data;
              wb.WbToRegs_port_sync    <= |wb.CtlToWb_port.dst;
            end
          end
        end
        WAIT_MEM: begin
          // Memory valid is checked first so it beats a coincident timeout.
          if (wb.MemToWb_port_sync) begin
            wb.WbToRegs_port.dst     <= ldDst;
            wb.WbToRegs_port.dstdata <= ldExtended;
            wb.WbToRegs_port_sync    <= |ldDst;
            state                    <= IDLE;
          end
`ifdef REGS_WB_TIMEOUT_EN
          else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This edge brings the count to TIMEOUT_CYCLES: abandon the load.
            waitCnt        <= CNT_W'(TIMEOUT_CYCLES);
            wb.WbToCtl_err <= 1'b1;
            state          <= IDLE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_wb_unit.sv
// Directed plus randomized bench for regs_wb_unit with a behavioural
// load-extension reference model.
module tb_regs_wb_unit;
  import top_level_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nTests = 0;
  int   nFail  = 0;

  logic [4:0]  expDst  = '0;
  logic [31:0] expData = '0;

  regs_wb_unit_if bus ();

`ifdef REGS_WB_TIMEOUT_EN
  regs_wb_unit #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .wb(bus));
`else
  regs_wb_unit dut (.clk(clk), .rst(rst), .wb(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: take the addressed byte/halfword arithmetically, then extend.
  function automatic logic [31:0] refExt(input logic [31:0] w, input int t, input int lsb);
    longint v;
    case (t)
      0, 4: begin
        v = longint'((w >> (8 * lsb)) & 32'hFF);
        if (t == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = longint'((w >> (16 * (lsb / 2))) & 32'hFFFF);
        if (t == 1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic expSync, input logic expNotify);
    check({tag, "_sync"},   64'(bus.WbToRegs_port_sync),      64'(expSync));
    check({tag, "_dst"},    64'(bus.WbToRegs_port.dst),       64'(expDst));
    check({tag, "_data"},   64'(bus.WbToRegs_port.dstdata),   64'(expData));
    check({tag, "_notify"}, 64'(bus.WbToCtl_port_notify),     64'(expNotify));
`ifdef REGS_WB_TIMEOUT_EN
    check({tag, "_err"},    64'(bus.WbToCtl_err),             64'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic [4:0] dst, input logic [31:0] data, input logic isLoad,
                        input logic [2:0] lt, input logic [1:0] lsb);
    bus.CtlToWb_port.dst       = dst;
    bus.CtlToWb_port.data      = data;
    bus.CtlToWb_port.is_load   = isLoad;
    bus.CtlToWb_port.load_type = lt;
    bus.CtlToWb_port.addr_lsb  = lsb;
  endtask

  task automatic aluReq(input logic [4:0] dst, input logic [31:0] data);
    setReq(dst, data, 1'b0, 3'd0, 2'd0);
    bus.CtlToWb_port_sync = 1'b1;
    tick();
    bus.CtlToWb_port_sync = 1'b0;
    expDst  = dst;
    expData = data;
    checkOut("alu", dst != 5'd0, 1'b1);
  endtask

  task automatic loadReq(input logic [4:0] dst, input logic [2:0] lt, input logic [1:0] lsb,
                         input logic [31:0] word, input int delay, input logic junk);
    setReq(dst, $urandom, 1'b1, lt, lsb);
    bus.CtlToWb_port_sync = 1'b1;
    tick();
    bus.CtlToWb_port_sync = 1'b0;
    checkOut("ld_accept", 1'b0, 1'b0);
    for (int i = 0; i < delay; i++) begin
      setReq(5'($urandom_range(1, 31)), $urandom, 1'b0, 3'd0, 2'd0);
      bus.CtlToWb_port_sync = junk;
      tick();
      checkOut("ld_wait", 1'b0, 1'b0);
    end
    bus.CtlToWb_port_sync = 1'b0;
    bus.MemToWb_port      = word;
    bus.MemToWb_port_sync = 1'b1;
    tick();
    bus.MemToWb_port_sync = 1'b0;
    expDst  = dst;
    expData = refExt(word, int'(lt), int'(lsb));
    checkOut("ld_done", dst != 5'd0, 1'b1);
  endtask

  task automatic idle(input int n, input logic memJunk);
    for (int i = 0; i < n; i++) begin
      bus.CtlToWb_port_sync = 1'b0;
      bus.MemToWb_port      = $urandom;
      bus.MemToWb_port_sync = memJunk;
      tick();
      bus.MemToWb_port_sync = 1'b0;
      checkOut("idle", 1'b0, 1'b1);
    end
  endtask

  initial begin
    setReq(5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    bus.CtlToWb_port_sync = 1'b0;
    bus.MemToWb_port      = '0;
    bus.MemToWb_port_sync = 1'b0;

    // Reset state
    #1;
    checkOut("reset", 1'b0, 1'b1);
    #11 rst = 1'b1;
    tick();
    checkOut("post_reset", 1'b0, 1'b1);

    // ALU write and strobe drop
    aluReq(5'd5, 32'hDEADBEEF);
    idle(1, 1'b0);

    // Load extension cases
    loadReq(5'd3, LB,  2'd3, 32'h80123456, 1, 1'b0);
    check("lb_val", 64'(bus.WbToRegs_port.dstdata), 64'hFFFFFF80);
    loadReq(5'd3, LBU, 2'd3, 32'h80123456, 0, 1'b0);
    check("lbu_val", 64'(bus.WbToRegs_port.dstdata), 64'h00000080);
    loadReq(5'd4, LH,  2'd2, 32'h80017FFF, 0, 1'b0);
    check("lh_val", 64'(bus.WbToRegs_port.dstdata), 64'hFFFF8001);
    loadReq(5'd4, LHU, 2'd0, 32'h80017FFF, 2, 1'b0);
    check("lhu_val", 64'(bus.WbToRegs_port.dstdata), 64'h00007FFF);
    loadReq(5'd6, LW,  2'd1, 32'hCAFEF00D, 0, 1'b0);
    check("lw_val", 64'(bus.WbToRegs_port.dstdata), 64'hCAFEF00D);
    loadReq(5'd6, 3'd7, 2'd3, 32'h89ABCDEF, 0, 1'b0);

    // Writes to x0
    aluReq(5'd0, 32'h00001234);
    idle(1, 1'b0);
    loadReq(5'd0, LW, 2'd0, 32'h55AA55AA, 1, 1'b0);
    idle(1, 1'b0);

    // Long wait with ignored requests, then back-to-back ALU writes
    loadReq(5'd10, LB, 2'd1, 32'h0000FF00, 3, 1'b1);
    idle(1, 1'b1);
    aluReq(5'd11, 32'h11111111);
    aluReq(5'd12, 32'h22222222);

    // Reset in the middle of a wait abandons the load
    setReq(5'd9, 32'd0, 1'b1, LW, 2'd0);
    bus.CtlToWb_port_sync = 1'b1;
    tick();
    bus.CtlToWb_port_sync = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    expDst  = '0;
    expData = '0;
    checkOut("rst_mid", 1'b0, 1'b1);
    #2 rst = 1'b1;
    bus.MemToWb_port      = 32'h12345678;
    bus.MemToWb_port_sync = 1'b1;
    tick();
    bus.MemToWb_port_sync = 1'b0;
    checkOut("rst_nowrite", 1'b0, 1'b1);

`ifdef REGS_WB_TIMEOUT_EN
    begin
      int errs;
      int writes;
      int errAt;
      errs = 0; writes = 0; errAt = -1;
      setReq(5'd7, 32'd0, 1'b1, LW, 2'd0);
      bus.CtlToWb_port_sync = 1'b1;
      tick();
      bus.CtlToWb_port_sync = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.WbToCtl_err === 1'b1) begin
          errs++;
          if (errAt < 0) errAt = i;
        end
        if (bus.WbToRegs_port_sync === 1'b1) writes++;
      end
      check("to_errs",   64'(errs),   64'd1);
      check("to_cycle",  64'(errAt),  64'd3);
      check("to_writes", 64'(writes), 64'd0);
      checkOut("to_after", 1'b0, 1'b1);
      // Memory valid on the timeout edge wins
      loadReq(5'd8, LHU, 2'd2, 32'hBEEF0000, 3, 1'b0);
    end
`endif

    // Randomized mix
    for (int it = 0; it < 300; it++) begin
      int kind;
      logic [4:0] d;
      kind = int'($urandom_range(0, 2));
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case (kind)
        0: aluReq(d, $urandom);
        1: loadReq(d, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        default: idle(1, 1'($urandom_range(0, 1)));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
